// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receiver state encoding, baud divisors, framing codes.
// No logic, so there is no latency and no flow control.
// Framing codes are the same ones the transmitter uses.
package uart_pkg;

    localparam int CLK_HZ     = 50_000_000;
    localparam int DIV_9600   = 326;
    localparam int DIV_2400   = 1302;
    localparam int OVERSAMPLE = 16;

    localparam logic WORD_7 = 1'b0;
    localparam logic WORD_8 = 1'b1;
    localparam logic STOP_1 = 1'b0;
    localparam logic STOP_2 = 1'b1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Received-character bus from the UART receiver to the checking/display logic.
// Signals are registered at the source; data_valid/frame_err are one-clock strobes.
// No backpressure: the consumer must take each strobe when it occurs.
interface uart_rx_if;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    modport master (output data_out, data_valid, frame_err, busy);
    modport slave  (input  data_out, data_valid, frame_err, busy);
endinterface

// File: rtl/uart_rx_tick.sv
// Oversample tick generator: one-clock tick every DIV clocks for the selected rate.
// Tick is registered; the first tick arrives DIV clocks after a restart.
// A reload pulse or a rate change restarts the count from zero.
module uart_rx_tick #(
    parameter int DIV_9600 = 326,
    parameter int DIV_2400 = 1302
) (
    input  logic clk,
    input  logic rst,
    input  logic sel,
    input  logic reload,
    output logic tick
);
    localparam logic [15:0] LAST_9600 = 16'(DIV_9600 - 1);
    localparam logic [15:0] LAST_2400 = 16'(DIV_2400 - 1);

    logic [15:0] cnt;
    logic [15:0] last;
    logic        sel_q;
    logic        restart;

    assign last    = sel ? LAST_2400 : LAST_9600;
    assign restart = reload | (sel != sel_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            sel_q <= 1'b0;
            tick  <= 1'b0;
        end else begin
            sel_q <= sel;
            tick  <= 1'b0;
            if (restart) begin
                cnt <= '0;
            end else if (cnt == last) begin
                cnt  <= '0;
                tick <= 1'b1;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end
endmodule

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled, 7/8 data bits, 1/2 stop bits, 9600/2400 baud.
// Strobe lands 2 sync clocks + 1 clock after the mid-point of the final stop bit.
// No backpressure; UART_RX_MAJORITY_EN selects 2-of-3 voting over ticks 7..9.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DIV_9600 = uart_pkg::DIV_9600,
    parameter int DIV_2400 = uart_pkg::DIV_2400
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     rx_en,
    input  logic     rate_sel,
    input  logic     word8,
    input  logic     stop2,
    input  logic     rxd,
    uart_rx_if.master rx
);
    localparam logic [3:0] MID_TICK = 4'(OVERSAMPLE / 2 - 1);

    rx_state_t  state;
    logic       rx_s1, rx_s2, rx_prev;
    logic       tick, tick_sel, start_det, decide, bit_val;
    logic [3:0] tcnt;
    logic [2:0] bcnt;
    logic [7:0] shreg;
    logic       stop_idx, err_acc;
    logic       w8_lat, s2_lat, rate_lat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rxd;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign start_det = (state == IDLE) & rx_prev & ~rx_s2 & rx_en;
    // Rate follows the live input only while idle; a frame keeps its latched rate.
    assign tick_sel  = (state == IDLE) ? rate_sel : rate_lat;

    uart_rx_tick #(
        .DIV_9600 (DIV_9600),
        .DIV_2400 (DIV_2400)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .sel    (tick_sel),
        .reload (start_det),
        .tick   (tick)
    );

`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0] DEC_TICK = MID_TICK + 4'd2;
    logic smp_a, smp_b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            smp_a <= 1'b1;
            smp_b <= 1'b1;
        end else if (tick) begin
            if (tcnt == MID_TICK)        smp_a <= rx_s2;
            if (tcnt == MID_TICK + 4'd1) smp_b <= rx_s2;
        end
    end

    assign bit_val = maj3(smp_a, smp_b, rx_s2);
`else
    localparam logic [3:0] DEC_TICK = MID_TICK;
    assign bit_val = rx_s2;
`endif

    assign decide = tick & (tcnt == DEC_TICK);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            tcnt          <= '0;
            bcnt          <= '0;
            shreg         <= '0;
            stop_idx      <= 1'b0;
            err_acc       <= 1'b0;
            w8_lat        <= WORD_8;
            s2_lat        <= STOP_1;
            rate_lat      <= 1'b0;
            rx.data_out   <= '0;
            rx.data_valid <= 1'b0;
            rx.frame_err  <= 1'b0;
            rx.busy       <= 1'b0;
        end else begin
            rx.data_valid <= 1'b0;
            rx.frame_err  <= 1'b0;
            if (tick) tcnt <= tcnt + 4'd1;

            case (state)
                IDLE: begin
                    if (start_det) begin
                        state    <= START;
                        tcnt     <= '0;
                        bcnt     <= '0;
                        shreg    <= '0;
                        stop_idx <= 1'b0;
                        err_acc  <= 1'b0;
                        w8_lat   <= word8;
                        s2_lat   <= stop2;
                        rate_lat <= rate_sel;
                    end
                end
                START: begin
                    if (decide) begin
                        if (bit_val) begin
                            state <= IDLE;
                        end else begin
                            rx.busy <= 1'b1;
                            state   <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (decide) begin
                        shreg[bcnt] <= bit_val;
                        if (bcnt == ((w8_lat == WORD_8) ? 3'd7 : 3'd6)) begin
                            bcnt  <= '0;
                            state <= STOP;
                        end else begin
                            bcnt <= bcnt + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (decide) begin
                        if ((s2_lat == STOP_2) && !stop_idx) begin
                            stop_idx <= 1'b1;
                            err_acc  <= ~bit_val;
                        end else begin
                            // Report at mid-stop so a back-to-back start edge is not missed.
                            rx.data_out   <= shreg;
                            rx.data_valid <= 1'b1;
                            rx.frame_err  <= err_acc | ~bit_val;
                            rx.busy       <= 1'b0;
                            state         <= bit_val ? IDLE : WAIT_IDLE;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s2) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with shortened baud divisors; a vector table plus
// hand-written sequences for latency, break, glitch, reset and sampling spikes.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int D96 = 4;
    localparam int D24 = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx_en = 1'b0;
    logic rate_sel = 1'b0;
    logic word8 = 1'b1;
    logic stop2 = 1'b0;
    logic rxd = 1'b1;

    uart_rx_if rxif ();

    uart_rx #(.DIV_9600(D96), .DIV_2400(D24)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_en    (rx_en),
        .rate_sel (rate_sel),
        .word8    (word8),
        .stop2    (stop2),
        .rxd      (rxd),
        .rx       (rxif)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       busy;
        int         cyc;
    } strobe_t;

    typedef struct {
        logic       rate;
        logic       w8;
        logic       s2;
        logic [7:0] d;
        logic [1:0] stopv;
        int         gap;
        logic [7:0] exp_d;
        logic       exp_fe;
    } vec_t;

    strobe_t log_q [256];
    int n_dv = 0;
    int cyc = 0;
    int busy_cnt = 0;
    int rd = 0;
    int n_chk = 0;
    int n_fail = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rxif.busy) busy_cnt <= busy_cnt + 1;
        if (rxif.data_valid && n_dv < 256) begin
            log_q[n_dv] <= '{rxif.data_out, rxif.frame_err, rxif.busy, cyc};
            n_dv <= n_dv + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic expect_one(input string name, input logic [7:0] exp_d, input logic exp_fe);
        chk({name, " strobes"}, 32'(n_dv - rd), 32'd1);
        if (n_dv > rd) begin
            chk({name, " data"}, 32'(log_q[rd].d), 32'(exp_d));
            chk({name, " ferr"}, 32'(log_q[rd].fe), 32'(exp_fe));
            chk({name, " busy@valid"}, 32'(log_q[rd].busy), 32'd0);
        end
        rd = n_dv;
    endtask

    task automatic expect_none(input string name);
        chk({name, " strobes"}, 32'(n_dv - rd), 32'd0);
        rd = n_dv;
    endtask

    // Drive one line level for nclk clocks; a 3-clock inverted spike is centred on clock spk.
    task automatic drive(input logic v, input int nclk, input int spk);
        for (int c = 0; c < nclk; c++) begin
            @(negedge clk);
            rxd = (spk >= 0 && c >= spk - 1 && c <= spk + 1) ? ~v : v;
        end
    endtask

    task automatic send(input logic rate, input logic w8, input logic s2, input logic [7:0] d,
                        input logic [1:0] stopv, input int spk, input logic [7:0] spk_mask);
        int bc;
        bc = 16 * (rate ? D24 : D96);
        drive(1'b0, bc, -1);
        for (int i = 0; i < (w8 ? 8 : 7); i++) drive(d[i], bc, spk_mask[i] ? spk : -1);
        drive(stopv[0], bc, -1);
        if (s2) drive(stopv[1], bc, -1);
    endtask

    task automatic config_rx(input logic rate, input logic w8, input logic s2);
        rate_sel = rate;
        word8    = w8;
        stop2    = s2;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected end of test");
        $fatal(1);
    end

    initial begin
        vec_t vt [5];
        int   c0, b0;

        vt[0] = '{1'b0, 1'b1, 1'b0, 8'hFF, 2'b11, 0,  8'hFF, 1'b0};
        vt[1] = '{1'b0, 1'b1, 1'b0, 8'h00, 2'b11, 32, 8'h00, 1'b0};
        vt[2] = '{1'b0, 1'b0, 1'b0, 8'hD5, 2'b11, 32, 8'h55, 1'b0};
        vt[3] = '{1'b1, 1'b1, 1'b1, 8'h3C, 2'b11, 64, 8'h3C, 1'b0};
        vt[4] = '{1'b0, 1'b1, 1'b1, 8'h81, 2'b10, 32, 8'h81, 1'b1};

        repeat (3) @(negedge clk);
        chk("reset data_out", 32'(rxif.data_out), 32'd0);
        chk("reset data_valid", 32'(rxif.data_valid), 32'd0);
        chk("reset frame_err", 32'(rxif.frame_err), 32'd0);
        chk("reset busy", 32'(rxif.busy), 32'd0);
        rst   = 1'b1;
        rx_en = 1'b1;
        drive(1'b1, 40, -1);
        expect_none("post-reset idle");

        for (int i = 0; i < 5; i++) begin
            config_rx(vt[i].rate, vt[i].w8, vt[i].s2);
            send(vt[i].rate, vt[i].w8, vt[i].s2, vt[i].d, vt[i].stopv, -1, 8'h00);
            expect_one($sformatf("vec%0d", i), vt[i].exp_d, vt[i].exp_fe);
            if (vt[i].gap > 0) drive(1'b1, vt[i].gap, -1);
        end

        // 2400 baud, 7 data bits, 2 stop bits: strobe at mid second stop bit.
        config_rx(1'b1, 1'b0, 1'b1);
        drive(1'b1, 32, -1);
        c0 = cyc;
        b0 = busy_cnt;
        send(1'b1, 1'b0, 1'b1, 8'h7F, 2'b11, -1, 8'h00);
        chk("latency busy cycles", 32'(busy_cnt - b0), 32'(144 * D24));
        if (n_dv > rd) chk_range("latency dv", log_q[rd].cyc - c0, 152 * D24, 152 * D24 + 3 * D24 + 8);
        expect_one("2400 7E2", 8'h7F, 1'b0);
        drive(1'b1, 64, -1);

        // Framing error followed by a break: one strobe, then silence until the line idles.
        config_rx(1'b0, 1'b1, 1'b0);
        send(1'b0, 1'b1, 1'b0, 8'h55, 2'b00, -1, 8'h00);
        expect_one("ferr frame", 8'h55, 1'b1);
        drive(1'b0, 3 * 16 * D96, -1);
        chk("break busy", 32'(rxif.busy), 32'd0);
        expect_none("break hold");
        drive(1'b1, 16 * D96, -1);
        send(1'b0, 1'b1, 1'b0, 8'hA5, 2'b11, -1, 8'h00);
        expect_one("after break", 8'hA5, 1'b0);
        drive(1'b1, 32, -1);

        // Short low glitch on an idle line is rejected at the start-bit check.
        b0 = busy_cnt;
        drive(1'b0, 16, -1);
        drive(1'b1, 128, -1);
        expect_none("glitch");
        chk("glitch busy cycles", 32'(busy_cnt - b0), 32'd0);
        send(1'b0, 1'b1, 1'b0, 8'h5A, 2'b11, -1, 8'h00);
        expect_one("after glitch", 8'h5A, 1'b0);
        drive(1'b1, 32, -1);

        // Asynchronous reset in the middle of the data bits of 0x3C.
        drive(1'b0, 16 * D96, -1);
        drive(1'b0, 16 * D96, -1);
        drive(1'b0, 16 * D96, -1);
        drive(1'b1, 8 * D96, -1);
        chk("busy before reset", 32'(rxif.busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("async rst data_out", 32'(rxif.data_out), 32'd0);
        chk("async rst data_valid", 32'(rxif.data_valid), 32'd0);
        chk("async rst frame_err", 32'(rxif.frame_err), 32'd0);
        chk("async rst busy", 32'(rxif.busy), 32'd0);
        drive(1'b1, 10, -1);
        rst = 1'b1;
        drive(1'b1, 128, -1);
        expect_none("aborted frame");
        send(1'b0, 1'b1, 1'b0, 8'hC3, 2'b11, -1, 8'h00);
        expect_one("after reset", 8'hC3, 1'b0);
        drive(1'b1, 32, -1);

        // Short spikes near the sampling point of the data bits of 0x96.
`ifdef UART_RX_MAJORITY_EN
        send(1'b0, 1'b1, 1'b0, 8'h96, 2'b11, 9 * D96 + 2, 8'hFF);
        expect_one("spike majority", 8'h96, 1'b0);
`else
        send(1'b0, 1'b1, 1'b0, 8'h96, 2'b11, 8 * D96 + 2, 8'h01);
        expect_one("spike single", 8'h97, 1'b0);
`endif
        drive(1'b1, 32, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
